// File: rtl/lsu_tcm_arb.sv
// LSU/IFU front end for the DTCM and ITCM single-port SRAMs: address decode, ITCM arbitration
// with a bounded LSU streak, and the one-cycle-later response strobes and read-data steering.
module lsu_tcm_arb #(
    parameter logic [31:0] ITCM_BASE = 32'h0000_0000,
    parameter int          ITCM_AW   = 16,
    parameter logic [31:0] DTCM_BASE = 32'h8000_0000,
    parameter int          DTCM_AW   = 16,
    parameter int          LSU_WIN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic [31:0]          lsu_req_addr,
    input  logic                 lsu_req_wen,
    input  logic [31:0]          lsu_req_wdata,
    input  logic [3:0]           lsu_req_wmask,
    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [31:0]          ifu_req_addr,
    output logic                 ifu_rsp_valid,
    output logic [31:0]          ifu_rsp_data,
    output logic                 itcm_cs,
    output logic                 itcm_we,
    output logic [ITCM_AW-3:0]   itcm_addr,
    output logic [31:0]          itcm_wdata,
    output logic [3:0]           itcm_wmask,
    input  logic [31:0]          itcm_rdata,
    output logic                 dtcm_cs,
    output logic                 dtcm_we,
    output logic [DTCM_AW-3:0]   dtcm_addr,
    output logic [31:0]          dtcm_wdata,
    output logic [3:0]           dtcm_wmask,
    input  logic [31:0]          dtcm_rdata,
    output logic                 res_from_dtcm,
    output logic                 res_from_itcm,
    output logic [31:0]          data_from_dtcm,
    output logic [31:0]          data_from_itcm,
    output logic                 lsu_buserr
);

    localparam int WCW = $clog2(LSU_WIN + 1);

    // Handshake: a request transfers in the cycle where valid && ready; a master seeing
    // ready=0 keeps valid and its payload stable. Ready never depends on SRAM state.

    logic hit_d, hit_i, miss;
    logic dtcm_acc, lsu_i_req, ifu_gnt, lsu_i_gnt;
    logic [WCW-1:0] win_cnt_q, win_cnt_d;
    logic rsp_d_q, rsp_d_d, rsp_d_ld_q, rsp_d_ld_d;
    logic rsp_i_lsu_q, rsp_i_lsu_d, rsp_i_ld_q, rsp_i_ld_d;
    logic rsp_i_ifu_q, rsp_i_ifu_d, err_q, err_d;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{lsu_req_addr[1:0], ifu_req_addr[31:ITCM_AW], ifu_req_addr[1:0]};

    assign hit_d     = lsu_req_addr[31:DTCM_AW] == DTCM_BASE[31:DTCM_AW];
    assign hit_i     = (lsu_req_addr[31:ITCM_AW] == ITCM_BASE[31:ITCM_AW]) && !hit_d;
    assign miss      = !hit_d && !hit_i;
    assign dtcm_acc  = lsu_req_valid && hit_d;
    assign lsu_i_req = lsu_req_valid && hit_i;

    // The IFU takes the port when the LSU is not asking, or once the LSU streak is exhausted.
    assign ifu_gnt   = ifu_req_valid && (!lsu_i_req || (win_cnt_q == WCW'(LSU_WIN)));
    assign lsu_i_gnt = lsu_i_req && !ifu_gnt;

    assign lsu_req_ready = lsu_req_valid && (hit_d || miss || lsu_i_gnt);
    assign ifu_req_ready = ifu_gnt;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (ifu_gnt || !ifu_req_valid) begin
            win_cnt_d = '0;
        end else if (lsu_i_gnt) begin
            win_cnt_d = win_cnt_q + WCW'(1);
        end
    end

    always_comb begin
        dtcm_cs    = dtcm_acc && rst_n;
        dtcm_we    = dtcm_cs && lsu_req_wen;
        dtcm_addr  = '0;
        dtcm_wdata = '0;
        dtcm_wmask = '0;
        if (dtcm_cs) begin
            dtcm_addr = lsu_req_addr[DTCM_AW-1:2];
        end
        if (dtcm_we) begin
            dtcm_wdata = lsu_req_wdata;
            dtcm_wmask = lsu_req_wmask;
        end
    end

    always_comb begin
        itcm_cs    = (lsu_i_gnt || ifu_gnt) && rst_n;
        itcm_we    = lsu_i_gnt && lsu_req_wen && rst_n;
        itcm_addr  = '0;
        itcm_wdata = '0;
        itcm_wmask = '0;
        if (rst_n && ifu_gnt) begin
            itcm_addr = ifu_req_addr[ITCM_AW-1:2];
        end else if (rst_n && lsu_i_gnt) begin
            itcm_addr = lsu_req_addr[ITCM_AW-1:2];
        end
        if (itcm_we) begin
            itcm_wdata = lsu_req_wdata;
            itcm_wmask = lsu_req_wmask;
        end
    end

    always_comb begin
        rsp_d_d     = dtcm_acc;
        rsp_d_ld_d  = dtcm_acc && !lsu_req_wen;
        rsp_i_lsu_d = lsu_i_gnt;
        rsp_i_ld_d  = lsu_i_gnt && !lsu_req_wen;
        rsp_i_ifu_d = ifu_gnt;
        err_d       = lsu_req_valid && miss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            rsp_d_q     <= 1'b0;
            rsp_d_ld_q  <= 1'b0;
            rsp_i_lsu_q <= 1'b0;
            rsp_i_ld_q  <= 1'b0;
            rsp_i_ifu_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            rsp_d_q     <= rsp_d_d;
            rsp_d_ld_q  <= rsp_d_ld_d;
            rsp_i_lsu_q <= rsp_i_lsu_d;
            rsp_i_ld_q  <= rsp_i_ld_d;
            rsp_i_ifu_q <= rsp_i_ifu_d;
            err_q       <= err_d;
        end
    end

    // Stores still strobe res_*, but their data lanes stay 0.
    assign res_from_dtcm  = rsp_d_q;
    assign res_from_itcm  = rsp_i_lsu_q;
    assign lsu_buserr     = err_q;
    assign ifu_rsp_valid  = rsp_i_ifu_q;
    assign data_from_dtcm = rsp_d_ld_q  ? dtcm_rdata : 32'h0;
    assign data_from_itcm = rsp_i_ld_q  ? itcm_rdata : 32'h0;
    assign ifu_rsp_data   = rsp_i_ifu_q ? itcm_rdata : 32'h0;

endmodule

// File: tb/tb_lsu_tcm_arb.sv
// Directed bench for lsu_tcm_arb: DTCM/ITCM loads and stores, ITCM arbitration pattern,
// bus error, concurrent DTCM+IFU traffic and reset in the middle of an access.
module tb_lsu_tcm_arb;

    logic        clk, rst_n;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic        itcm_cs, itcm_we, dtcm_cs, dtcm_we;
    logic [13:0] itcm_addr, dtcm_addr;
    logic [31:0] itcm_wdata, dtcm_wdata, itcm_rdata, dtcm_rdata;
    logic [3:0]  itcm_wmask, dtcm_wmask;
    logic        res_from_dtcm, res_from_itcm, lsu_buserr;
    logic [31:0] data_from_dtcm, data_from_itcm;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_tcm_arb dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data),
        .itcm_cs(itcm_cs), .itcm_we(itcm_we), .itcm_addr(itcm_addr),
        .itcm_wdata(itcm_wdata), .itcm_wmask(itcm_wmask), .itcm_rdata(itcm_rdata),
        .dtcm_cs(dtcm_cs), .dtcm_we(dtcm_we), .dtcm_addr(dtcm_addr),
        .dtcm_wdata(dtcm_wdata), .dtcm_wmask(dtcm_wmask), .dtcm_rdata(dtcm_rdata),
        .res_from_dtcm(res_from_dtcm), .res_from_itcm(res_from_itcm),
        .data_from_dtcm(data_from_dtcm), .data_from_itcm(data_from_itcm),
        .lsu_buserr(lsu_buserr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'h0;
        lsu_req_wmask = 4'h0;
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h0;
    endtask

    task automatic lsu_drive(input logic [31:0] addr, input logic wen,
                             input logic [31:0] wdata, input logic [3:0] wmask);
        lsu_req_valid = 1'b1;
        lsu_req_addr  = addr;
        lsu_req_wen   = wen;
        lsu_req_wdata = wdata;
        lsu_req_wmask = wmask;
    endtask

    // Inputs change on the negedge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic exp_lsu_g, exp_ifu_g, prev_lsu_g, prev_ifu_g;

        rst_n      = 1'b0;
        dtcm_rdata = 32'hDEAD_BEEF;
        itcm_rdata = 32'h1234_5678;
        idle_inputs();

        // Reset values
        #1;
        check_eq("rst_res_dtcm", {31'b0, res_from_dtcm}, 32'h0);
        check_eq("rst_res_itcm", {31'b0, res_from_itcm}, 32'h0);
        check_eq("rst_ifu_rsp",  {31'b0, ifu_rsp_valid}, 32'h0);
        check_eq("rst_buserr",   {31'b0, lsu_buserr}, 32'h0);
        check_eq("rst_cs",       {30'b0, itcm_cs, dtcm_cs}, 32'h0);
        check_eq("rst_data_d",   data_from_dtcm, 32'h0);
        repeat (2) next_cycle();
        rst_n = 1'b1;

        // DTCM load
        next_cycle();
        lsu_drive(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        #1;
        check_eq("dl_ready",  {31'b0, lsu_req_ready}, 32'h1);
        check_eq("dl_cs",     {30'b0, itcm_cs, dtcm_cs}, 32'h1);
        check_eq("dl_we",     {31'b0, dtcm_we}, 32'h0);
        check_eq("dl_addr",   {18'b0, dtcm_addr}, 32'h4);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("dl_res",    {31'b0, res_from_dtcm}, 32'h1);
        check_eq("dl_data",   data_from_dtcm, 32'hDEAD_BEEF);
        check_eq("dl_res_i",  {30'b0, lsu_buserr, res_from_itcm}, 32'h0);
        next_cycle();
        #1;
        check_eq("dl_res_one", {31'b0, res_from_dtcm}, 32'h0);
        check_eq("dl_data_0",  data_from_dtcm, 32'h0);

        // ITCM store with IFU idle
        next_cycle();
        lsu_drive(32'h0000_0008, 1'b1, 32'hAABB_CCDD, 4'b0011);
        #1;
        check_eq("is_ready", {31'b0, lsu_req_ready}, 32'h1);
        check_eq("is_cs_we", {30'b0, itcm_cs, itcm_we}, 32'h3);
        check_eq("is_mask",  {28'b0, itcm_wmask}, 32'h3);
        check_eq("is_addr",  {18'b0, itcm_addr}, 32'h2);
        check_eq("is_wdata", itcm_wdata, 32'hAABB_CCDD);
        check_eq("is_dcs",   {31'b0, dtcm_cs}, 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("is_res",   {31'b0, res_from_itcm}, 32'h1);
        check_eq("is_data0", data_from_itcm, 32'h0);
        check_eq("is_res_d", {31'b0, res_from_dtcm}, 32'h0);

        // Both masters hold ITCM requests: LSU x4, IFU x1, repeating
        prev_lsu_g = 1'b0;
        prev_ifu_g = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            lsu_drive(32'h0000_0100, 1'b0, 32'h0, 4'h0);
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'h0000_0200;
            itcm_rdata    = 32'h5000_0000 + 32'(k);
            exp_ifu_g = (k % 5) == 4;
            exp_lsu_g = !exp_ifu_g;
            #1;
            check_eq($sformatf("arb_lsu_rdy_%0d", k), {31'b0, lsu_req_ready}, {31'b0, exp_lsu_g});
            check_eq($sformatf("arb_ifu_rdy_%0d", k), {31'b0, ifu_req_ready}, {31'b0, exp_ifu_g});
            check_eq($sformatf("arb_addr_%0d", k), {18'b0, itcm_addr},
                     exp_ifu_g ? 32'h80 : 32'h40);
            check_eq($sformatf("arb_ifu_rsp_%0d", k), {31'b0, ifu_rsp_valid}, {31'b0, prev_ifu_g});
            check_eq($sformatf("arb_lsu_rsp_%0d", k), {31'b0, res_from_itcm}, {31'b0, prev_lsu_g});
            check_eq($sformatf("arb_ifu_data_%0d", k), ifu_rsp_data,
                     prev_ifu_g ? 32'h5000_0000 + 32'(k) : 32'h0);
            check_eq($sformatf("arb_lsu_data_%0d", k), data_from_itcm,
                     prev_lsu_g ? 32'h5000_0000 + 32'(k) : 32'h0);
            prev_lsu_g = exp_lsu_g;
            prev_ifu_g = exp_ifu_g;
        end
        next_cycle();
        idle_inputs();
        itcm_rdata = 32'h1234_5678;
        #1;
        check_eq("arb_tail_ifu_rsp", {31'b0, ifu_rsp_valid}, 32'h1);
        check_eq("arb_tail_ifu_data", ifu_rsp_data, 32'h1234_5678);
        check_eq("arb_tail_lsu_rsp", {31'b0, res_from_itcm}, 32'h0);

        // Miss -> bus error
        next_cycle();
        lsu_drive(32'h4000_0000, 1'b0, 32'h0, 4'h0);
        #1;
        check_eq("miss_ready", {31'b0, lsu_req_ready}, 32'h1);
        check_eq("miss_cs",    {30'b0, itcm_cs, dtcm_cs}, 32'h0);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("miss_err",   {31'b0, lsu_buserr}, 32'h1);
        check_eq("miss_res",   {30'b0, res_from_itcm, res_from_dtcm}, 32'h0);
        next_cycle();
        #1;
        check_eq("miss_err_one", {31'b0, lsu_buserr}, 32'h0);

        // Concurrent DTCM loads and IFU fetches, three cycles back to back
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            lsu_drive(32'h8000_0000 + 32'(4 * k), 1'b0, 32'h0, 4'h0);
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'h0000_0010 + 32'(4 * k);
            #1;
            check_eq($sformatf("cc_cs_%0d", k), {30'b0, itcm_cs, dtcm_cs}, 32'h3);
            check_eq($sformatf("cc_rdy_%0d", k), {30'b0, lsu_req_ready, ifu_req_ready}, 32'h3);
            check_eq($sformatf("cc_daddr_%0d", k), {18'b0, dtcm_addr}, 32'(k));
            check_eq($sformatf("cc_iaddr_%0d", k), {18'b0, itcm_addr}, 32'(4 + k));
            check_eq($sformatf("cc_rsp_%0d", k), {30'b0, res_from_dtcm, ifu_rsp_valid},
                     (k == 0) ? 32'h0 : 32'h3);
        end
        next_cycle();
        idle_inputs();
        #1;
        check_eq("cc_rsp_tail", {30'b0, res_from_dtcm, ifu_rsp_valid}, 32'h3);
        next_cycle();
        #1;
        check_eq("cc_rsp_done", {30'b0, res_from_dtcm, ifu_rsp_valid}, 32'h0);

        // Build up win_cnt, then reset during a DTCM load accept
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            lsu_drive(32'h0000_0100, 1'b0, 32'h0, 4'h0);
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'h0000_0200;
        end
        next_cycle();
        #1;
        check_eq("rm_win_cnt_pre", 32'(dut.win_cnt_q), 32'h2);
        lsu_drive(32'h8000_0020, 1'b0, 32'h0, 4'h0);
        ifu_req_valid = 1'b0;
        #1;
        check_eq("rm_dcs_pre", {31'b0, dtcm_cs}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rm_win_cnt_async", 32'(dut.win_cnt_q), 32'h0);
        check_eq("rm_cs_in_rst", {28'b0, itcm_cs, itcm_we, dtcm_cs, dtcm_we}, 32'h0);
        check_eq("rm_ready_in_rst", {31'b0, lsu_req_ready}, 32'h1);
        next_cycle();
        #1;
        check_eq("rm_res_in_rst", {31'b0, res_from_dtcm}, 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        next_cycle();
        #1;
        check_eq("rm_res_after", {31'b0, res_from_dtcm}, 32'h0);
        check_eq("rm_data_after", data_from_dtcm, 32'h0);
        check_eq("rm_win_cnt_after", 32'(dut.win_cnt_q), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
